// File: rtl/outp_disp_pkg.sv
// Shared types and constants for the Outp display driver: conversion FSM states,
// active-low seven-segment codes ({g,f,e,d,c,b,a}) and conversion sizing.
package outp_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_e;

  localparam int unsigned IN_W        = 14;
  localparam int unsigned BCD_W       = 16;
  localparam logic [IN_W-1:0] MAX_DEC = 14'd9999;
  localparam int unsigned CONV_CYCLES = 14;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = SEG_0;
      4'd1:    seg_decode = SEG_1;
      4'd2:    seg_decode = SEG_2;
      4'd3:    seg_decode = SEG_3;
      4'd4:    seg_decode = SEG_4;
      4'd5:    seg_decode = SEG_5;
      4'd6:    seg_decode = SEG_6;
      4'd7:    seg_decode = SEG_7;
      4'd8:    seg_decode = SEG_8;
      4'd9:    seg_decode = SEG_9;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/outp_display_driver_if.sv
// Bus between the Main datapath result and the 4-digit display pins.
interface outp_display_driver_if;
  import outp_disp_pkg::*;

  logic [IN_W-1:0] outp_in;
  logic [6:0]      seg;
  logic [3:0]      an;
  logic            busy;
  logic            ovf;

  modport master (output outp_in, input seg, an, busy, ovf);
  modport slave  (input outp_in, output seg, an, busy, ovf);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: binary is loaded into the low bits, BCD accumulates
// in the top 16 bits, one adjust+shift per step.
module bin2bcd_seq import outp_disp_pkg::*; (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [IN_W-1:0]  bin_in,
  output logic [BCD_W-1:0] bcd,
  output logic             last_step
);

  logic [IN_W+BCD_W-1:0] sr_q, sr_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [BCD_W-1:0]      adj;

  always_comb begin
    adj = '0;
    for (int i = 0; i < BCD_W/4; i++) begin
      adj[4*i +: 4] = (sr_q[IN_W+4*i +: 4] >= 4'd5) ? sr_q[IN_W+4*i +: 4] + 4'd3
                                                    : sr_q[IN_W+4*i +: 4];
    end
  end

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load) begin
      sr_d  = {{BCD_W{1'b0}}, bin_in};
      cnt_d = '0;
    end else if (step) begin
      // inputs never exceed 9999, so nothing is lost off the top nibble
      sr_d  = {adj, sr_q[IN_W-1:0]} << 1;
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign bcd       = sr_q[IN_W +: BCD_W];
  assign last_step = (cnt_q == 4'(CONV_CYCLES-1));

endmodule

// File: rtl/outp_display_driver.sv
// Converts Outp to BCD on change and multiplexes it onto a 4-digit display.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module outp_display_driver import outp_disp_pkg::*; #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input logic                 clk,
  input logic                 rst_n,
  outp_display_driver_if.slave bus
);

  localparam int unsigned CW = $clog2(SCAN_DIV);

  conv_state_e      state_q, state_d;
  logic [IN_W-1:0]  last_val_q, last_val_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic             ovf_q, ovf_d;
  logic [3:0][3:0]  dig_q, dig_d;
  logic [CW-1:0]    scan_cnt_q, scan_cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [6:0]       seg_q, seg_d;
  logic             blank;
  logic             load, step, last_step;
  logic [BCD_W-1:0] bcd;

  bin2bcd_seq u_b2b (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .step      (step),
    .bin_in    (bus.outp_in),
    .bcd       (bcd),
    .last_step (last_step)
  );

  always_comb begin
    state_d    = state_q;
    last_val_d = last_val_q;
    ovf_pend_d = ovf_pend_q;
    ovf_d      = ovf_q;
    dig_d      = dig_q;
    load       = 1'b0;
    step       = 1'b0;
    unique case (state_q)
      IDLE: if (bus.outp_in != last_val_q) begin
        load       = 1'b1;
        last_val_d = bus.outp_in;
        ovf_pend_d = (bus.outp_in > MAX_DEC);
        state_d    = (bus.outp_in > MAX_DEC) ? DONE : SHIFT;
      end
      SHIFT: begin
        step = 1'b1;
        if (last_step) state_d = DONE;
      end
      DONE: begin
        // overflow keeps the old digits; ovf alone selects the dashes
        ovf_d = ovf_pend_q;
        if (!ovf_pend_q) dig_d = bcd;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (scan_cnt_q == CW'(SCAN_DIV-1)) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 2'd1;
    end
  end

  // seg is built from next-state digit/index so it lands with an and with DONE
  always_comb begin
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    case (idx_d)
      2'd3:    blank = (dig_d[3] == 4'd0);
      2'd2:    blank = (dig_d[3] == 4'd0) && (dig_d[2] == 4'd0);
      2'd1:    blank = (dig_d[3:1] == '0);
      default: blank = 1'b0;
    endcase
`endif
    if (ovf_d)      seg_d = SEG_DASH;
    else if (blank) seg_d = SEG_BLANK;
    else            seg_d = seg_decode(dig_d[idx_d]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_val_q <= '0;
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      dig_q      <= '0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      seg_q      <= SEG_0;
    end else begin
      state_q    <= state_d;
      last_val_q <= last_val_d;
      ovf_pend_q <= ovf_pend_d;
      ovf_q      <= ovf_d;
      dig_q      <= dig_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
    end
  end

  assign bus.seg  = seg_q;
  assign bus.an   = ~(4'b0001 << idx_q);
  assign bus.busy = (state_q != IDLE);
  assign bus.ovf  = ovf_q;

endmodule
